// File: rtl/frame_pkg.sv
// frame_pkg
// Shared definitions for the 16-bit framing path: word width, the default
// frame sync word and the framer state encoding.
package frame_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 16'hEB90;

  // Each state names the kind of word currently held on the output register.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN,
    S_DATA,
    S_CSUM
  } frame_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Show-ahead (first-word-fall-through) single-clock FIFO. The oldest stored
// word is always visible on rd_data while the FIFO is not empty; asserting
// rd_en consumes it.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset, empties the FIFO
//   wr_en   in   write request, ignored while full
//   wr_data in   word to store
//   rd_en   in   consume the head word, ignored while empty
//   rd_data out  head word
//   full    out  count == DEPTH
//   empty   out  count == 0
//   count   out  registered number of stored words
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // A simultaneous write and read leaves the count unchanged.
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/frame_pack16.sv
// frame_pack16
// Buffers 16-bit payload words and emits framed bursts:
//   SYNC_WORD, length, payload words (FIFO order), checksum.
// The checksum is the 16-bit wrap-around sum of the length word and the
// payload words. Frames start when MAX_LEN words are buffered, or on flush
// with a non-empty FIFO. Back-to-back frames follow without a gap.
//
// Ports:
//   Clk        in   rising-edge clock
//   Rst        in   synchronous active-low reset
//   din        in   payload word
//   din_v      in   payload valid, accepted when din_v && din_rdy
//   flush      in   emit a partial frame (sampled in IDLE and CSUM only)
//   din_rdy    out  FIFO not full, low while Rst is asserted
//   dout       out  registered framed output word
//   dout_v     out  registered dout valid
//   frame_done out  one-cycle pulse together with the checksum word
//   ovf        out  sticky: a word arrived while the FIFO was full
module frame_pack16
  import frame_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter int                MAX_LEN   = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] din,
  input  logic        din_v,
  input  logic        flush,
  output logic        din_rdy,
  output logic [15:0] dout,
  output logic        dout_v,
  output logic        frame_done,
  output logic        ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] MAX_LEN_C = CW'(MAX_LEN);
  localparam logic [CW-1:0] LEN_ONE   = CW'(1);

  frame_state_e      state_q, state_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              dout_v_q, dout_v_d;
  logic              frame_done_q, frame_done_d;
  logic              ovf_q, ovf_d;

  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              start;
  logic [CW-1:0]     len_next;

  assign din_rdy = Rst && !fifo_full;
  assign fifo_wr = din_v && din_rdy;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Rst),
    .wr_en   (fifo_wr),
    .wr_data (din),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (cnt)
  );

  // Only consulted in IDLE and CSUM, so flush elsewhere has no effect.
  assign start    = (cnt >= MAX_LEN_C) || (flush && (cnt != '0));
  assign len_next = (cnt >= MAX_LEN_C) ? MAX_LEN_C : cnt;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // rem_q counts payload words still to pop after the one on dout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SYNC;
      S_SYNC:  state_d = S_LEN;
      S_LEN:   state_d = S_DATA;
      S_DATA:  if (rem_q == '0) state_d = S_CSUM;
      S_CSUM:  state_d = start ? S_SYNC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output words are loaded on the edge that enters each state, so dout
  // always carries the word belonging to the current state.
  always_comb begin
    len_d        = len_q;
    rem_d        = rem_q;
    csum_d       = csum_q;
    dout_d       = '0;
    dout_v_d     = 1'b0;
    frame_done_d = 1'b0;
    fifo_rd      = 1'b0;
    case (state_d)
      S_SYNC: begin
        dout_d   = SYNC_WORD;
        dout_v_d = 1'b1;
        len_d    = len_next;
      end
      S_LEN: begin
        dout_d   = {{(WORD_W-CW){1'b0}}, len_q};
        dout_v_d = 1'b1;
        csum_d   = {{(WORD_W-CW){1'b0}}, len_q};
      end
      S_DATA: begin
        fifo_rd  = !fifo_empty;
        dout_d   = fifo_head;
        dout_v_d = 1'b1;
        csum_d   = csum_q + fifo_head;
        rem_d    = (state_q == S_LEN) ? (len_q - LEN_ONE) : (rem_q - LEN_ONE);
      end
      S_CSUM: begin
        dout_d       = csum_q;
        dout_v_d     = 1'b1;
        frame_done_d = 1'b1;
      end
      default: begin
        dout_d = '0;
      end
    endcase
  end

  assign ovf_d = ovf_q || (din_v && fifo_full);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      len_q        <= '0;
      rem_q        <= '0;
      csum_q       <= '0;
      dout_q       <= '0;
      dout_v_q     <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      len_q        <= len_d;
      rem_q        <= rem_d;
      csum_q       <= csum_d;
      dout_q       <= dout_d;
      dout_v_q     <= dout_v_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_v     = dout_v_q;
  assign frame_done = frame_done_q;
  assign ovf        = ovf_q;

endmodule
